// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a shared multi-cycle datapath (fetch/decode/execute/memory/writeback).
// Optional retired-instruction counter is enabled by defining MC_CTRL_PERF_EN.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic       alusrc_a,
  output logic [1:0] alusrc_b,
  output logic [2:0] aluop,
  output logic [1:0] pcsource,
  output logic [3:0] state,
  output logic       illegal,
  output logic       mem_err
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] instr_retired
`endif
);

  // Handshake: a memory state raises mem_read/mem_write and holds it, unchanged,
  // until the cycle mem_ready=1; that cycle completes the transfer and the FSM moves on.

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_JR       = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 2);
  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state_q;
  state_t            state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic              in_mem;
  logic              timeout;
  logic              unused_zero;

  // The zero flag qualifies pc_write_cond in the datapath, not here.
  assign unused_zero = zero;
  assign state       = state_q;

  assign in_mem  = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  // Trap on the cycle the counter would reach MEM_TIMEOUT; mem_ready that cycle wins.
  assign timeout = (MEM_TIMEOUT != 0) && in_mem && !mem_ready && (wait_cnt >= WAIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      mem_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        wait_cnt <= '0;
      else if (in_mem && !mem_ready && (wait_cnt != WAIT_MAX))
        wait_cnt <= wait_cnt + 1'b1;
      if ((state_q == S_DECODE) && (state_d == S_TRAP))
        illegal <= 1'b1;
      if (timeout)
        mem_err <= 1'b1;
    end
  end

`ifdef MC_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst)
      instr_retired <= '0;
    else if ((state_d == S_FETCH) && (state_q != S_FETCH))
      instr_retired <= instr_retired + 1'b1;
  end
`else
  logic [CNT_W-1:0] unused_perf;
  assign unused_perf = '0;
`endif

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    regdst        = 2'b00;
    memtoreg      = 2'b00;
    alusrc_a      = 1'b0;
    alusrc_b      = 2'b00;
    aluop         = 3'b000;
    pcsource      = 2'b00;

    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        alusrc_b = 2'b01;
        aluop    = 3'b011;
        ir_write = mem_ready;
        pc_write = mem_ready;
        if (timeout)        state_d = S_TRAP;
        else if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrc_b = 2'b11;
        aluop    = 3'b011;
        if (opcode == 6'h00) begin
          if (func[5:3] == 3'b000) state_d = S_EXEC_R;
          else if (func == 6'h08)  state_d = S_JR;
          else                     state_d = S_TRAP;
        end else if (opcode[5:3] == 3'b010) begin
          state_d = S_EXEC_I;
        end else if ((opcode == 6'h23) || (opcode == 6'h2B)) begin
          state_d = S_MEM_ADDR;
        end else if (opcode == 6'h30) begin
          state_d = S_BRANCH;
        end else if ((opcode == 6'h31) || (opcode == 6'h33)) begin
          state_d = S_JUMP;
        end else begin
          state_d = S_TRAP;
        end
      end
      S_EXEC_R: begin
        alusrc_a = 1'b1;
        aluop    = func[2:0];
        state_d  = S_ALU_WB;
      end
      S_EXEC_I: begin
        alusrc_a = 1'b1;
        alusrc_b = 2'b10;
        aluop    = opcode[2:0];
        state_d  = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        regdst    = (opcode == 6'h00) ? 2'b01 : 2'b00;
        state_d   = S_FETCH;
      end
      S_MEM_ADDR: begin
        alusrc_a = 1'b1;
        alusrc_b = 2'b10;
        aluop    = 3'b011;
        state_d  = (opcode == 6'h2B) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (timeout)        state_d = S_TRAP;
        else if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write = 1'b1;
        memtoreg  = 2'b01;
        state_d   = S_FETCH;
      end
      S_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (timeout)        state_d = S_TRAP;
        else if (mem_ready) state_d = S_FETCH;
      end
      S_BRANCH: begin
        alusrc_a      = 1'b1;
        aluop         = 3'b111;
        pc_write_cond = 1'b1;
        pcsource      = 2'b01;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pcsource = 2'b10;
        // jal links the already-incremented PC into r31.
        if (opcode == 6'h33) begin
          reg_write = 1'b1;
          regdst    = 2'b10;
          memtoreg  = 2'b10;
        end
        state_d = S_FETCH;
      end
      S_JR: begin
        pc_write = 1'b1;
        pcsource = 2'b11;
        state_d  = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    // Reset aborts whatever is in flight without touching architectural state.
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: each cycle's expected control word is queued
// when its inputs are driven and compared on the following falling edge.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write, reg_write;
  logic [1:0] regdst, memtoreg, alusrc_b, pcsource;
  logic       alusrc_a;
  logic [2:0] aluop;
  logic [3:0] state;
  logic       illegal, mem_err;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] instr_retired;
`endif

  multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .regdst(regdst),
    .memtoreg(memtoreg), .alusrc_a(alusrc_a), .alusrc_b(alusrc_b), .aluop(aluop),
    .pcsource(pcsource), .state(state), .illegal(illegal), .mem_err(mem_err)
`ifdef MC_CTRL_PERF_EN
    , .instr_retired(instr_retired)
`endif
  );

  // clock/reset block
  always #5 clk = ~clk;

  // {state, pcw, pcwc, irw, iord, mr, mw, rw, regdst, memtoreg, srca, srcb, aluop, pcsrc, illegal, mem_err}
  logic [24:0] obs;
  assign obs = {state, pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write, reg_write,
                regdst, memtoreg, alusrc_a, alusrc_b, aluop, pcsource, illegal, mem_err};

  logic [24:0] exp_q[$];
  string       tag_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic        e_ill = 1'b0;
  logic        e_me = 1'b0;

  // scoreboard
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [24:0] e;
      string       t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      vectors++;
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", t, obs, e);
      end
    end
  end

  function automatic logic [24:0] v(input logic [3:0] st, input logic pcw, input logic pcwc,
                                    input logic irw, input logic ad, input logic mr, input logic mw,
                                    input logic rw, input logic [1:0] rd, input logic [1:0] m2r,
                                    input logic sa, input logic [1:0] sb, input logic [2:0] op,
                                    input logic [1:0] ps);
    return {st, pcw, pcwc, irw, ad, mr, mw, rw, rd, m2r, sa, sb, op, ps, e_ill, e_me};
  endfunction

  function automatic logic [24:0] ef(input logic rdy);
    return v(4'd0, rdy, 1'b0, rdy, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd1, 3'd3, 2'd0);
  endfunction
  function automatic logic [24:0] ef_rst();
    return v(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd1, 3'd3, 2'd0);
  endfunction
  function automatic logic [24:0] ed();
    return v(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd3, 3'd3, 2'd0);
  endfunction
  function automatic logic [24:0] er(input logic [2:0] op);
    return v(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd0, op, 2'd0);
  endfunction
  function automatic logic [24:0] ei(input logic [2:0] op);
    return v(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd2, op, 2'd0);
  endfunction
  function automatic logic [24:0] ew(input logic [1:0] rd);
    return v(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rd, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0);
  endfunction
  function automatic logic [24:0] ema();
    return v(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd2, 3'd3, 2'd0);
  endfunction
  function automatic logic [24:0] emr();
    return v(4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0);
  endfunction
  function automatic logic [24:0] emwb();
    return v(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0, 2'd0, 3'd0, 2'd0);
  endfunction
  function automatic logic [24:0] emw(input logic mw);
    return v(4'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mw, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0);
  endfunction
  function automatic logic [24:0] eb();
    return v(4'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd0, 3'd7, 2'd1);
  endfunction
  function automatic logic [24:0] ej(input logic jal);
    return v(4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, jal, jal ? 2'd2 : 2'd0, jal ? 2'd2 : 2'd0,
             1'b0, 2'd0, 3'd0, 2'd2);
  endfunction
  function automatic logic [24:0] ejr();
    return v(4'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 3'd0, 2'd3);
  endfunction
  function automatic logic [24:0] et();
    return v(4'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 3'd0, 2'd0);
  endfunction

  // driver: one clock cycle of inputs plus the control word expected during it
  task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic rdy,
                     input logic r, input logic [24:0] e, input string t);
    @(posedge clk);
    #1;
    opcode    = op;
    func      = fn;
    zero      = z;
    mem_ready = rdy;
    rst       = r;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  initial begin
    rst = 1'b1; opcode = 6'h00; func = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    cyc(6'h00, 6'h03, 1'b0, 1'b1, 1'b1, ef_rst(), "reset");

    // add: 0,1,2,8
    cyc(6'h00, 6'h03, 1'b0, 1'b1, 1'b0, ef(1'b1), "add_fetch");
    cyc(6'h00, 6'h03, 1'b0, 1'b1, 1'b0, ed(), "add_decode");
    cyc(6'h00, 6'h03, 1'b0, 1'b1, 1'b0, er(3'd3), "add_exec");
    cyc(6'h00, 6'h03, 1'b0, 1'b1, 1'b0, ew(2'd1), "add_wb");

    // immediate ALU op 0x16 (nand)
    cyc(6'h16, 6'h00, 1'b0, 1'b1, 1'b0, ef(1'b1), "alui_fetch");
    cyc(6'h16, 6'h00, 1'b0, 1'b1, 1'b0, ed(), "alui_decode");
    cyc(6'h16, 6'h00, 1'b0, 1'b1, 1'b0, ei(3'd6), "alui_exec");
    cyc(6'h16, 6'h00, 1'b0, 1'b1, 1'b0, ew(2'd0), "alui_wb");

    // lw with one fetch wait and three read waits
    cyc(6'h23, 6'h00, 1'b0, 1'b0, 1'b0, ef(1'b0), "lw_fetch_wait");
    cyc(6'h23, 6'h00, 1'b0, 1'b1, 1'b0, ef(1'b1), "lw_fetch");
    cyc(6'h23, 6'h00, 1'b0, 1'b1, 1'b0, ed(), "lw_decode");
    cyc(6'h23, 6'h00, 1'b0, 1'b1, 1'b0, ema(), "lw_addr");
    for (int i = 0; i < 3; i++)
      cyc(6'h23, 6'h00, 1'b0, 1'b0, 1'b0, emr(), "lw_rd_wait");
    cyc(6'h23, 6'h00, 1'b0, 1'b1, 1'b0, emr(), "lw_rd");
    cyc(6'h23, 6'h00, 1'b0, 1'b1, 1'b0, emwb(), "lw_wb");

    // sw with one write wait
    cyc(6'h2B, 6'h00, 1'b0, 1'b1, 1'b0, ef(1'b1), "sw_fetch");
    cyc(6'h2B, 6'h00, 1'b0, 1'b1, 1'b0, ed(), "sw_decode");
    cyc(6'h2B, 6'h00, 1'b0, 1'b1, 1'b0, ema(), "sw_addr");
    cyc(6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, emw(1'b1), "sw_wr_wait");
    cyc(6'h2B, 6'h00, 1'b0, 1'b1, 1'b0, emw(1'b1), "sw_wr");

    // beq taken and not taken: identical Moore outputs
    cyc(6'h30, 6'h00, 1'b1, 1'b1, 1'b0, ef(1'b1), "beq1_fetch");
    cyc(6'h30, 6'h00, 1'b1, 1'b1, 1'b0, ed(), "beq1_decode");
    cyc(6'h30, 6'h00, 1'b1, 1'b1, 1'b0, eb(), "beq1_branch");
    cyc(6'h30, 6'h00, 1'b0, 1'b1, 1'b0, ef(1'b1), "beq0_fetch");
    cyc(6'h30, 6'h00, 1'b0, 1'b1, 1'b0, ed(), "beq0_decode");
    cyc(6'h30, 6'h00, 1'b0, 1'b1, 1'b0, eb(), "beq0_branch");

    // jal, j, jr
    cyc(6'h33, 6'h00, 1'b0, 1'b1, 1'b0, ef(1'b1), "jal_fetch");
    cyc(6'h33, 6'h00, 1'b0, 1'b1, 1'b0, ed(), "jal_decode");
    cyc(6'h33, 6'h00, 1'b0, 1'b1, 1'b0, ej(1'b1), "jal_jump");
    cyc(6'h31, 6'h00, 1'b0, 1'b1, 1'b0, ef(1'b1), "j_fetch");
    cyc(6'h31, 6'h00, 1'b0, 1'b1, 1'b0, ed(), "j_decode");
    cyc(6'h31, 6'h00, 1'b0, 1'b1, 1'b0, ej(1'b0), "j_jump");
    cyc(6'h00, 6'h08, 1'b0, 1'b1, 1'b0, ef(1'b1), "jr_fetch");
    cyc(6'h00, 6'h08, 1'b0, 1'b1, 1'b0, ed(), "jr_decode");
    cyc(6'h00, 6'h08, 1'b0, 1'b1, 1'b0, ejr(), "jr_jr");

    // illegal opcode 0x3F, sticky until reset
    cyc(6'h3F, 6'h00, 1'b0, 1'b1, 1'b0, ef(1'b1), "ill_op_fetch");
    cyc(6'h3F, 6'h00, 1'b0, 1'b1, 1'b0, ed(), "ill_op_decode");
    e_ill = 1'b1;
    cyc(6'h3F, 6'h00, 1'b0, 1'b1, 1'b0, et(), "ill_op_trap");
    cyc(6'h3F, 6'h00, 1'b0, 1'b1, 1'b0, et(), "ill_op_trap_hold");
    cyc(6'h3F, 6'h00, 1'b0, 1'b1, 1'b1, et(), "ill_op_rst_cycle");
    e_ill = 1'b0;
    // illegal func 0x09
    cyc(6'h00, 6'h09, 1'b0, 1'b1, 1'b0, ef(1'b1), "ill_fn_fetch");
    cyc(6'h00, 6'h09, 1'b0, 1'b1, 1'b0, ed(), "ill_fn_decode");
    e_ill = 1'b1;
    cyc(6'h00, 6'h09, 1'b0, 1'b1, 1'b0, et(), "ill_fn_trap");
    cyc(6'h00, 6'h09, 1'b0, 1'b1, 1'b1, et(), "ill_fn_rst_cycle");
    e_ill = 1'b0;

    // 14 waits then ready on the 15th: ready wins, no trap
    for (int i = 0; i < 14; i++)
      cyc(6'h00, 6'h07, 1'b0, 1'b0, 1'b0, ef(1'b0), "edge_fetch_wait");
    cyc(6'h00, 6'h07, 1'b0, 1'b1, 1'b0, ef(1'b1), "edge_fetch_ready");
    cyc(6'h00, 6'h07, 1'b0, 1'b1, 1'b0, ed(), "edge_decode");
    cyc(6'h00, 6'h07, 1'b0, 1'b1, 1'b0, er(3'd7), "edge_exec");
    cyc(6'h00, 6'h07, 1'b0, 1'b1, 1'b0, ew(2'd1), "edge_wb");

    // 15 waits in FETCH: timeout trap
    for (int i = 0; i < 15; i++)
      cyc(6'h00, 6'h00, 1'b0, 1'b0, 1'b0, ef(1'b0), "to_fetch_wait");
    e_me = 1'b1;
    cyc(6'h00, 6'h00, 1'b0, 1'b0, 1'b0, et(), "to_trap");
    cyc(6'h00, 6'h00, 1'b0, 1'b1, 1'b0, et(), "to_trap_hold");
    cyc(6'h00, 6'h00, 1'b0, 1'b1, 1'b1, et(), "to_rst_cycle");
    e_me = 1'b0;

    // reset during a write wait
    cyc(6'h2B, 6'h00, 1'b0, 1'b1, 1'b0, ef(1'b1), "abort_fetch");
    cyc(6'h2B, 6'h00, 1'b0, 1'b1, 1'b0, ed(), "abort_decode");
    cyc(6'h2B, 6'h00, 1'b0, 1'b1, 1'b0, ema(), "abort_addr");
    cyc(6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, emw(1'b1), "abort_wr_wait");
    cyc(6'h2B, 6'h00, 1'b0, 1'b0, 1'b1, emw(1'b0), "abort_wr_rst");
    cyc(6'h00, 6'h01, 1'b0, 1'b1, 1'b0, ef(1'b1), "abort_refetch");
    cyc(6'h00, 6'h01, 1'b0, 1'b1, 1'b0, ed(), "abort_decode2");

    // final report
    @(negedge clk);
    #1;
    vectors++;
    assert (exp_q.size() == 0) else begin
      miscompares++;
      $error("FAIL drain: observed %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
